// File: rtl/pin_check_arbiter.sv
// Two-lane PIN checker sharing one comparator: round-robin grant, fixed-latency compare,
// per-lane consecutive-failure counting with lockout until an operator clear.
module pin_check_arbiter #(
    parameter logic [15:0] PASSWORD     = 16'h3761,
    parameter int          MAX_ATTEMPTS = 3,
    parameter int          CHECK_LAT    = 2,
    parameter int          CNT_W        = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req,
    input  logic [15:0]          pin0,
    input  logic [15:0]          pin1,
    input  logic [1:0]           clear_block,
    output logic [1:0]           grant,
    output logic [1:0]           ack,
    output logic                 pass,
    output logic                 fail,
    output logic [1:0]           blocked,
    output logic                 busy,
    output logic [1:0]           dbg_state,
    output logic [2*CNT_W-1:0]   dbg_cnt
);
    // Handshake: req[i] is a level held until ack[i]; ack is a single-cycle pulse and
    // pass/fail are qualified by it. A lane must drop req for a cycle before it is re-granted.

    localparam int LAT_W = $clog2(CHECK_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(CHECK_LAT);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_ATTEMPTS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [15:0]           pin_q, pin_d;
    logic [1:0]            armed_q, armed_d;
    logic                  rr_last_q, rr_last_d;
    logic [1:0]            blocked_q, blocked_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0] eligible;
    logic       match;
    logic       pick;
    logic       g_idx;

    assign eligible = req & armed_q & ~blocked_q;
    assign match    = (pin_q == PASSWORD);
    assign g_idx    = grant_q[1];

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        lat_d     = lat_q;
        pin_d     = pin_q;
        armed_d   = armed_q | ~req;
        rr_last_d = rr_last_q;
        blocked_d = blocked_q;
        cnt_d     = cnt_q;
        pick      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|eligible) begin
                    // On a tie the lane that did not win last time goes first.
                    pick      = (eligible == 2'b11) ? ~rr_last_q : eligible[1];
                    grant_d   = pick ? 2'b10 : 2'b01;
                    pin_d     = pick ? pin1 : pin0;
                    armed_d[pick] = 1'b0;
                    rr_last_d = pick;
                    lat_d     = LAT_LOAD;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                if (lat_q == '0) state_d = S_RESP;
                else             lat_d   = lat_q - 1'b1;
            end
            S_RESP: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
                if (match) begin
                    cnt_d[g_idx] = '0;
                end else if (cnt_q[g_idx] != MAX_CNT) begin
                    cnt_d[g_idx] = cnt_q[g_idx] + 1'b1;
                    if (cnt_q[g_idx] + 1'b1 == MAX_CNT) blocked_d[g_idx] = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
        endcase

        // Operator clear overrides a same-cycle failure update.
        for (int i = 0; i < 2; i++) begin
            if (clear_block[i]) begin
                cnt_d[i]     = '0;
                blocked_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            grant_q   <= 2'b00;
            lat_q     <= '0;
            pin_q     <= '0;
            armed_q   <= 2'b11;
            rr_last_q <= 1'b1;
            blocked_q <= 2'b00;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            lat_q     <= lat_d;
            pin_q     <= pin_d;
            armed_q   <= armed_d;
            rr_last_q <= rr_last_d;
            blocked_q <= blocked_d;
            cnt_q     <= cnt_d;
        end
    end

    assign grant     = grant_q;
    assign ack       = (state_q == S_RESP) ? grant_q : 2'b00;
    assign pass      = (state_q == S_RESP) &  match;
    assign fail      = (state_q == S_RESP) & ~match;
    assign blocked   = blocked_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;
    assign dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_pin_check_arbiter.sv
// Directed bench for pin_check_arbiter: latency, pass/fail, lockout, round-robin, clear and reset.
module tb_pin_check_arbiter;
    localparam int CHECK_LAT = 2;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] pin0, pin1;
    logic [1:0]  clear_block;
    logic [1:0]  grant, ack, blocked;
    logic        pass, fail, busy;
    logic [1:0]  dbg_state;
    logic [3:0]  dbg_cnt;

    int err_cnt = 0;
    int chk_cnt = 0;

    pin_check_arbiter #(
        .PASSWORD(16'h3761), .MAX_ATTEMPTS(3), .CHECK_LAT(CHECK_LAT), .CNT_W(2)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .pin0(pin0), .pin1(pin1),
        .clear_block(clear_block), .grant(grant), .ack(ack), .pass(pass), .fail(fail),
        .blocked(blocked), .busy(busy), .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Full request/response on one lane; the PIN is corrupted right after grant to prove latching.
    task automatic transact(input int lane, input logic [15:0] pin, input logic exp_pass);
        logic [1:0] oh;
        oh = (lane == 0) ? 2'b01 : 2'b10;
        if (lane == 0) pin0 = pin; else pin1 = pin;
        req = req | oh;
        tick();
        check("grant", 32'(grant), 32'(oh));
        check("busy", 32'(busy), 32'd1);
        if (lane == 0) pin0 = ~pin; else pin1 = ~pin;
        repeat (CHECK_LAT) begin
            tick();
            check("ack_early", 32'(ack), 32'd0);
        end
        tick();
        check("ack", 32'(ack), 32'(oh));
        check("pass", 32'(pass), 32'(exp_pass));
        check("fail", 32'(fail), 32'(!exp_pass));
        req = req & ~oh;
        tick();
        check("idle_grant", 32'(grant), 32'd0);
        check("idle_ack", 32'(ack), 32'd0);
    endtask

    initial begin
        rst = 1'b0; req = 2'b00; pin0 = 16'h0; pin1 = 16'h0; clear_block = 2'b00;
        tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_pf", 32'({pass, fail}), 32'd0);
        check("rst_blocked", 32'(blocked), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", 32'(dbg_cnt), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // T1
        transact(0, 16'h3761, 1'b1);
        check("t1_cnt", 32'(dbg_cnt), 32'd0);

        // T2
        transact(0, 16'h1235, 1'b0);
        check("t2_cnt1", 32'(dbg_cnt), 32'h1);
        check("t2_blk1", 32'(blocked), 32'd0);
        transact(0, 16'h1234, 1'b0);
        check("t2_cnt2", 32'(dbg_cnt), 32'h2);
        check("t2_blk2", 32'(blocked), 32'd0);
        transact(0, 16'h3761, 1'b1);
        check("t2_cnt3", 32'(dbg_cnt), 32'h0);
        check("t2_blk3", 32'(blocked), 32'd0);

        // T3
        transact(1, 16'h1235, 1'b0);
        transact(1, 16'h1234, 1'b0);
        check("t3_blk_pre", 32'(blocked), 32'd0);
        transact(1, 16'h1368, 1'b0);
        check("t3_blk", 32'(blocked), 32'b10);
        check("t3_cnt", 32'(dbg_cnt), 32'hC);
        req[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t3_no_grant", 32'(grant), 32'd0);
        end
        transact(0, 16'h3761, 1'b1);
        req[1] = 1'b0;
        clear_block = 2'b10;
        tick();
        clear_block = 2'b00;
        check("t3_clr_blk", 32'(blocked), 32'd0);
        check("t3_clr_cnt", 32'(dbg_cnt), 32'd0);

        // T4
        rst = 1'b0;
        tick();
        rst = 1'b1;
        pin0 = 16'h3761; pin1 = 16'h3761; req = 2'b11;
        for (int r = 0; r < 4; r++) begin
            logic [1:0] exp_g;
            exp_g = (r % 2 == 1) ? 2'b10 : 2'b01;
            tick();
            check("t4_grant", 32'(grant), 32'(exp_g));
            req = 2'b00;
            tick();
            req = 2'b11;
            tick();
            tick();
            check("t4_ack", 32'(ack), 32'(exp_g));
            check("t4_pass", 32'(pass), 32'd1);
            tick();
            check("t4_idle", 32'(grant), 32'd0);
        end
        req = 2'b00;
        tick();

        // T5a
        pin0 = 16'h3761; req = 2'b01;
        tick();
        check("t5_grant", 32'(grant), 32'b01);
        repeat (CHECK_LAT) tick();
        tick();
        check("t5_ack", 32'(ack), 32'b01);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t5_held", 32'(grant), 32'd0);
        end
        req = 2'b00;
        tick();
        req = 2'b01;
        tick();
        check("t5_regrant", 32'(grant), 32'b01);
        repeat (CHECK_LAT) tick();
        tick();
        check("t5_ack2", 32'(ack), 32'b01);
        check("t5_pass2", 32'(pass), 32'd1);
        req = 2'b00;
        tick();

        // T5b
        transact(1, 16'h1235, 1'b0);
        transact(1, 16'h1234, 1'b0);
        check("t5b_cnt2", 32'(dbg_cnt), 32'h8);
        pin1 = 16'h1368; req = 2'b10;
        tick();
        check("t5b_grant", 32'(grant), 32'b10);
        repeat (CHECK_LAT) tick();
        tick();
        check("t5b_ack", 32'(ack), 32'b10);
        check("t5b_fail", 32'(fail), 32'd1);
        clear_block = 2'b10; req = 2'b00;
        tick();
        clear_block = 2'b00;
        check("t5b_blk", 32'(blocked), 32'd0);
        check("t5b_cnt", 32'(dbg_cnt), 32'd0);
        transact(1, 16'h3761, 1'b1);

        // T6
        transact(1, 16'h1234, 1'b0);
        check("t6_cnt_pre", 32'(dbg_cnt), 32'h4);
        pin0 = 16'h3761; req = 2'b01;
        tick();
        check("t6_grant", 32'(grant), 32'b01);
        tick();
        rst = 1'b0;
        #1;
        check("t6_rst_grant", 32'(grant), 32'd0);
        check("t6_rst_ack", 32'(ack), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_state", 32'(dbg_state), 32'd0);
        check("t6_rst_cnt", 32'(dbg_cnt), 32'd0);
        req = 2'b00;
        tick();
        check("t6_no_ack", 32'(ack), 32'd0);
        rst = 1'b1;
        tick();
        transact(0, 16'h3761, 1'b1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
